// File: rtl/sw_pe_array_ctrl.sv
// Affine-gap Smith-Waterman controller with a systolic PE array.
// A query S (up to PE_NUM bases) is loaded one base per PE, then the database
// T is streamed through PE0. Every PE evaluates one cell per advancing cycle.
// The best local score is tracked with its (S, T) end coordinates.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   i_match/i_mismatch/i_gap_open/i_gap_ext  scoring parameters (static per job)
//   i_start, i_clear                    job start (IDLE only), synchronous abort
//   i_s_len, i_t_len                    job lengths, latched at start
//   i_s_base/i_s_valid/o_s_ready        S load handshake
//   i_t_base/i_t_valid/o_t_ready        T stream handshake
//   o_busy, o_done                      not-IDLE flag, one-cycle result pulse
//   o_score, o_s_end, o_t_end           best score and its 0-based end cell

// One array cell. It holds its S base and its previous-column state:
// H(k,j-1), E(k,j-1) and the diagonal H(k-1,j-1). It registers H, F, the
// T base and the T index for the next cell.
module sw_pe #(
  parameter int SCORE_W = 10,
  parameter int T_LEN_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_adv,
  input  logic               i_en,
  input  logic               i_ld,
  input  logic [1:0]         i_ld_base,
  input  logic [SCORE_W-1:0] i_match,
  input  logic [SCORE_W-1:0] i_mismatch,
  input  logic [SCORE_W-1:0] i_gap_open,
  input  logic [SCORE_W-1:0] i_gap_ext,
  input  logic               i_v,
  input  logic [1:0]         i_t,
  input  logic [T_LEN_W-1:0] i_tj,
  input  logic [SCORE_W-1:0] i_h,
  input  logic [SCORE_W-1:0] i_f,
  output logic               o_v,
  output logic [1:0]         o_t,
  output logic [T_LEN_W-1:0] o_tj,
  output logic [SCORE_W-1:0] o_h,
  output logic [SCORE_W-1:0] o_f
);
  function automatic logic [SCORE_W-1:0] sub_sat(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  function automatic logic [SCORE_W-1:0] add_sat(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] max2(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [1:0]         s_q, s_d, t_q, t_d;
  logic               v_q, v_d;
  logic [T_LEN_W-1:0] tj_q, tj_d;
  logic [SCORE_W-1:0] h_q, h_d, e_q, e_d, f_q, f_d, dg_q, dg_d;
  logic [SCORE_W-1:0] sub_h, e_new, f_new, h_new;

  // Scores are unsigned, so the max with 0 in the H recurrence is implicit.
  always_comb begin
    sub_h = (s_q == i_t) ? add_sat(dg_q, i_match) : sub_sat(dg_q, i_mismatch);
    e_new = max2(sub_sat(h_q, i_gap_open), sub_sat(e_q, i_gap_ext));
    f_new = max2(sub_sat(i_h, i_gap_open), sub_sat(i_f, i_gap_ext));
    h_new = max2(sub_h, max2(e_new, f_new));
  end

  always_comb begin
    s_d  = s_q;
    v_d  = v_q;
    t_d  = t_q;
    tj_d = tj_q;
    h_d  = h_q;
    e_d  = e_q;
    f_d  = f_q;
    dg_d = dg_q;
    if (i_ld) s_d = i_ld_base;
    if (i_adv) begin
      v_d = i_v & i_en;
      // Bubbles leave the column state untouched; only real cells move it.
      if (i_v && i_en) begin
        t_d  = i_t;
        tj_d = i_tj;
        h_d  = h_new;
        e_d  = e_new;
        f_d  = f_new;
        dg_d = i_h;
      end
    end
    if (i_clr) begin
      s_d  = '0;
      v_d  = 1'b0;
      t_d  = '0;
      tj_d = '0;
      h_d  = '0;
      e_d  = '0;
      f_d  = '0;
      dg_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      v_q  <= 1'b0;
      t_q  <= '0;
      tj_q <= '0;
      h_q  <= '0;
      e_q  <= '0;
      f_q  <= '0;
      dg_q <= '0;
    end else begin
      s_q  <= s_d;
      v_q  <= v_d;
      t_q  <= t_d;
      tj_q <= tj_d;
      h_q  <= h_d;
      e_q  <= e_d;
      f_q  <= f_d;
      dg_q <= dg_d;
    end
  end

  assign o_v  = v_q;
  assign o_t  = t_q;
  assign o_tj = tj_q;
  assign o_h  = h_q;
  assign o_f  = f_q;
endmodule

module sw_pe_array_ctrl #(
  parameter int PE_NUM  = 8,
  parameter int SCORE_W = 10,
  parameter int T_LEN_W = 12,
  parameter int S_IDX_W = $clog2(PE_NUM) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] i_match,
  input  logic [SCORE_W-1:0] i_mismatch,
  input  logic [SCORE_W-1:0] i_gap_open,
  input  logic [SCORE_W-1:0] i_gap_ext,
  input  logic               i_start,
  input  logic               i_clear,
  input  logic [S_IDX_W-1:0] i_s_len,
  input  logic [T_LEN_W-1:0] i_t_len,
  input  logic [1:0]         i_s_base,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  input  logic [1:0]         i_t_base,
  input  logic               i_t_valid,
  output logic               o_t_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [SCORE_W-1:0] o_score,
  output logic [S_IDX_W-1:0] o_s_end,
  output logic [T_LEN_W-1:0] o_t_end
);
  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [S_IDX_W-1:0] s_len_q, s_len_d, k_q, k_d, drn_q, drn_d, s_end_q, s_end_d;
  logic [T_LEN_W-1:0] t_len_q, t_len_d, t_cnt_q, t_cnt_d, t_end_q, t_end_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               s_ready_q, s_ready_d, t_ready_q, t_ready_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic s_beat, t_beat, adv, pe_clr;

  logic [PE_NUM-1:0]              pe_v, pe_en, pe_ld, c_v;
  logic [PE_NUM-1:0][1:0]         pe_t, c_t;
  logic [PE_NUM-1:0][T_LEN_W-1:0] pe_tj, c_tj;
  logic [PE_NUM-1:0][SCORE_W-1:0] pe_h, pe_f, c_h, c_f;

  logic [SCORE_W-1:0] scan_h;
  logic [S_IDX_W-1:0] scan_k;
  logic [T_LEN_W-1:0] scan_j;
  logic               unused_tail;

  // Ready flops are only high in LOAD/CALC, so a beat implies the state.
  assign s_beat = i_s_valid & s_ready_q;
  assign t_beat = i_t_valid & t_ready_q;
  assign adv    = t_beat | (state_q == DRAIN);
  assign pe_clr = i_clear | ((state_q == IDLE) & i_start);

  // PE0 sees the row -1 boundary (H=F=0) and the incoming T beat.
  assign c_v  = {pe_v[PE_NUM-2:0], t_beat};
  assign c_t  = {pe_t[PE_NUM-2:0], i_t_base};
  assign c_tj = {pe_tj[PE_NUM-2:0], t_cnt_q};
  assign c_h  = {pe_h[PE_NUM-2:0], {SCORE_W{1'b0}}};
  assign c_f  = {pe_f[PE_NUM-2:0], {SCORE_W{1'b0}}};

  for (genvar g = 0; g < PE_NUM; g++) begin : g_pe
    assign pe_en[g] = (s_len_q > S_IDX_W'(g));
    assign pe_ld[g] = s_beat && (k_q == S_IDX_W'(g));
    sw_pe #(.SCORE_W(SCORE_W), .T_LEN_W(T_LEN_W)) u_pe (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (pe_clr),
      .i_adv      (adv),
      .i_en       (pe_en[g]),
      .i_ld       (pe_ld[g]),
      .i_ld_base  (i_s_base),
      .i_match    (i_match),
      .i_mismatch (i_mismatch),
      .i_gap_open (i_gap_open),
      .i_gap_ext  (i_gap_ext),
      .i_v        (c_v[g]),
      .i_t        (c_t[g]),
      .i_tj       (c_tj[g]),
      .i_h        (c_h[g]),
      .i_f        (c_f[g]),
      .o_v        (pe_v[g]),
      .o_t        (pe_t[g]),
      .o_tj       (pe_tj[g]),
      .o_h        (pe_h[g]),
      .o_f        (pe_f[g])
    );
  end

  assign unused_tail = ^{pe_t[PE_NUM-1], pe_f[PE_NUM-1]};

  // Strictly-greater scan in ascending PE order: ties keep the current best
  // (earlier cycle) or the lowest PE index within this cycle.
  always_comb begin
    scan_h = best_q;
    scan_k = s_end_q;
    scan_j = t_end_q;
    for (int i = 0; i < PE_NUM; i++) begin
      if (pe_v[i] && (pe_h[i] > scan_h)) begin
        scan_h = pe_h[i];
        scan_k = S_IDX_W'(i);
        scan_j = pe_tj[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_len_d = s_len_q;
    t_len_d = t_len_q;
    k_d     = k_q;
    t_cnt_d = t_cnt_q;
    drn_d   = drn_q;
    best_d  = best_q;
    s_end_d = s_end_q;
    t_end_d = t_end_q;
    if (adv) begin
      best_d  = scan_h;
      s_end_d = scan_k;
      t_end_d = scan_j;
    end
    case (state_q)
      IDLE: begin
        if (i_start) begin
          s_len_d = i_s_len;
          t_len_d = i_t_len;
          k_d     = '0;
          t_cnt_d = '0;
          drn_d   = '0;
          best_d  = '0;
          s_end_d = '0;
          t_end_d = '0;
          if ((i_s_len == '0) || (i_s_len > S_IDX_W'(PE_NUM)) || (i_t_len == '0))
            state_d = DONE;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (s_beat) begin
          k_d = k_q + S_IDX_W'(1);
          if (k_q == s_len_q - S_IDX_W'(1)) state_d = CALC;
        end
      end
      CALC: begin
        if (t_beat) begin
          t_cnt_d = t_cnt_q + T_LEN_W'(1);
          if (t_cnt_q == t_len_q - T_LEN_W'(1)) state_d = DRAIN;
        end
      end
      // s_len bubble cycles flush the last column out of PE s_len-1 and
      // into the best register.
      DRAIN: begin
        drn_d = drn_q + S_IDX_W'(1);
        if (drn_q == s_len_q - S_IDX_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_clear) begin
      state_d = IDLE;
      best_d  = '0;
      s_end_d = '0;
      t_end_d = '0;
    end
  end

  always_comb begin
    s_ready_d = (state_d == LOAD);
    t_ready_d = (state_d == CALC);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == DONE) && !i_clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_len_q   <= '0;
      t_len_q   <= '0;
      k_q       <= '0;
      t_cnt_q   <= '0;
      drn_q     <= '0;
      best_q    <= '0;
      s_end_q   <= '0;
      t_end_q   <= '0;
      s_ready_q <= 1'b0;
      t_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_len_q   <= s_len_d;
      t_len_q   <= t_len_d;
      k_q       <= k_d;
      t_cnt_q   <= t_cnt_d;
      drn_q     <= drn_d;
      best_q    <= best_d;
      s_end_q   <= s_end_d;
      t_end_q   <= t_end_d;
      s_ready_q <= s_ready_d;
      t_ready_q <= t_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_s_ready = s_ready_q;
  assign o_t_ready = t_ready_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_score   = best_q;
  assign o_s_end   = s_end_q;
  assign o_t_end   = t_end_q;
endmodule

// File: tb/tb_sw_pe_array_ctrl.sv
// Directed bench for sw_pe_array_ctrl: a table of alignment jobs with
// hand-computed results, plus sequences for abort, reset and degenerate jobs.
module tb_sw_pe_array_ctrl;
  localparam int PE_NUM  = 8;
  localparam int SCORE_W = 10;
  localparam int T_LEN_W = 12;
  localparam int S_IDX_W = $clog2(PE_NUM) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [SCORE_W-1:0] i_match, i_mismatch, i_gap_open, i_gap_ext;
  logic               i_start, i_clear;
  logic [S_IDX_W-1:0] i_s_len;
  logic [T_LEN_W-1:0] i_t_len;
  logic [1:0]         i_s_base, i_t_base;
  logic               i_s_valid, i_t_valid;
  logic               o_s_ready, o_t_ready, o_busy, o_done;
  logic [SCORE_W-1:0] o_score;
  logic [S_IDX_W-1:0] o_s_end;
  logic [T_LEN_W-1:0] o_t_end;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sw_pe_array_ctrl #(.PE_NUM(PE_NUM), .SCORE_W(SCORE_W), .T_LEN_W(T_LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_gap_open(i_gap_open), .i_gap_ext(i_gap_ext),
    .i_start(i_start), .i_clear(i_clear), .i_s_len(i_s_len), .i_t_len(i_t_len),
    .i_s_base(i_s_base), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .i_t_base(i_t_base), .i_t_valid(i_t_valid), .o_t_ready(o_t_ready),
    .o_busy(o_busy), .o_done(o_done), .o_score(o_score), .o_s_end(o_s_end), .o_t_end(o_t_end)
  );

  typedef struct {
    string name;
    int    match, mis, gopen, gext;
    string s, t;
    bit    stall;
    int    exp_score, exp_s, exp_t;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input int m, input int mi, input int go, input int ge,
                              input string s, input string t, input bit st,
                              input int es, input int ess, input int et);
    vec_t v;
    v.name = nm; v.match = m; v.mis = mi; v.gopen = go; v.gext = ge;
    v.s = s; v.t = t; v.stall = st;
    v.exp_score = es; v.exp_s = ess; v.exp_t = et;
    return v;
  endfunction

  function automatic logic [1:0] b2(input byte c);
    if (c == "A") return 2'd0;
    if (c == "C") return 2'd1;
    if (c == "G") return 2'd2;
    return 2'd3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int  idx, cyc, d;
    bit  vv;
    @(negedge clk);
    i_match    = SCORE_W'(v.match);
    i_mismatch = SCORE_W'(v.mis);
    i_gap_open = SCORE_W'(v.gopen);
    i_gap_ext  = SCORE_W'(v.gext);
    i_s_len    = S_IDX_W'(v.s.len());
    i_t_len    = T_LEN_W'(v.t.len());
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    // A beat is counted when valid is driven while ready is high; the
    // following rising edge accepts it.
    idx = 0; cyc = 0;
    while (idx < v.s.len() && cyc < 500) begin
      vv = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_s_valid = vv;
      i_s_base  = b2(v.s[idx]);
      if (vv && o_s_ready) idx++;
      @(negedge clk); cyc++;
    end
    i_s_valid = 1'b0;
    check({v.name, " s_beats"}, idx, v.s.len());
    idx = 0; cyc = 0;
    while (idx < v.t.len() && cyc < 500) begin
      vv = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_t_valid = vv;
      i_t_base  = b2(v.t[idx]);
      if (vv && o_t_ready) idx++;
      @(negedge clk); cyc++;
    end
    i_t_valid = 1'b0;
    check({v.name, " t_beats"}, idx, v.t.len());
    // d counts edges after the one that accepted the last T beat.
    d = 0;
    while (!o_done && d < 100) begin
      @(negedge clk); d++;
    end
    check({v.name, " done_latency"}, d, v.s.len() + 1);
    check({v.name, " score"}, o_score, v.exp_score);
    check({v.name, " s_end"}, o_s_end, v.exp_s);
    check({v.name, " t_end"}, o_t_end, v.exp_t);
    @(negedge clk);
    check({v.name, " done_pulse"}, o_done, 0);
    check({v.name, " score_hold"}, o_score, v.exp_score);
  endtask

  task automatic run_degen(input string name, input int sl, input int tl);
    @(negedge clk);
    i_s_len = S_IDX_W'(sl);
    i_t_len = T_LEN_W'(tl);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({name, " done_early"}, o_done, 0);
    check({name, " busy"}, o_busy, 1);
    @(negedge clk);
    check({name, " done"}, o_done, 1);
    check({name, " score"}, o_score, 0);
    check({name, " ends"}, {o_s_end, o_t_end}, 0);
    @(negedge clk);
    check({name, " idle"}, {o_done, o_busy}, 0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " busy"}, o_busy, 0);
    check({name, " done"}, o_done, 0);
    check({name, " s_ready"}, o_s_ready, 0);
    check({name, " t_ready"}, o_t_ready, 0);
    check({name, " score"}, o_score, 0);
    check({name, " s_end"}, o_s_end, 0);
    check({name, " t_end"}, o_t_end, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst_n = 1'b0;
    i_match = '0; i_mismatch = '0; i_gap_open = '0; i_gap_ext = '0;
    i_start = 1'b0; i_clear = 1'b0; i_s_len = '0; i_t_len = '0;
    i_s_base = '0; i_s_valid = 1'b0; i_t_base = '0; i_t_valid = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk("exact",   2,   1, 3, 1, "ACGT",     "ACGT",     1'b0, 8,    3, 3));
    vecs.push_back(mk("nomatch", 2,   1, 3, 1, "AAAA",     "CCCC",     1'b0, 0,    0, 0));
    vecs.push_back(mk("gap",     2,   1, 3, 1, "ACGT",     "ACTGT",    1'b0, 5,    3, 4));
    vecs.push_back(mk("gap_stl", 2,   1, 3, 1, "ACGT",     "ACTGT",    1'b1, 5,    3, 4));
    vecs.push_back(mk("tie",     2,   1, 3, 1, "AC",       "ACAC",     1'b0, 4,    1, 1));
    vecs.push_back(mk("full",    2,   1, 3, 1, "ACGTACGT", "ACGTACGT", 1'b0, 16,   7, 7));
    vecs.push_back(mk("sat",     300, 1, 3, 1, "ACGT",     "ACGT",     1'b0, 1023, 3, 3));
    vecs.push_back(mk("tie_stl", 2,   1, 3, 1, "AC",       "ACAC",     1'b1, 4,    1, 1));

    foreach (vecs[i]) run_job(vecs[i]);

    // Abort mid-CALC: S=ACGT, two T beats (A, C), then clear.
    @(negedge clk);
    i_match = 2; i_mismatch = 1; i_gap_open = 3; i_gap_ext = 1;
    i_s_len = 4; i_t_len = 4; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_s_valid = 1'b1;
      i_s_base  = 2'(i);
      @(negedge clk);
    end
    i_s_valid = 1'b0;
    i_t_valid = 1'b1; i_t_base = 2'd0;
    @(negedge clk);
    i_t_base = 2'd1;
    @(negedge clk);
    i_t_valid = 1'b0;
    check("clr pre_busy", o_busy, 1);
    check("clr pre_t_ready", o_t_ready, 1);
    check("clr pre_score", o_score, 2);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    check("clr busy", o_busy, 0);
    check("clr t_ready", o_t_ready, 0);
    check("clr score", o_score, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_done) done_seen++;
      @(negedge clk);
    end
    check("clr no_done", done_seen, 0);
    run_job(vecs[2]);

    run_degen("slen0", 0, 4);
    run_degen("slen_big", 9, 4);
    run_job(vecs[0]);
    run_degen("tlen0", 4, 0);

    // Reset pulse mid-LOAD after one S beat.
    @(negedge clk);
    i_s_len = 4; i_t_len = 4; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_s_valid = 1'b1; i_s_base = 2'd3;
    @(negedge clk);
    check("rst_mid pre_busy", o_busy, 1);
    check("rst_mid pre_s_ready", o_s_ready, 1);
    rst_n = 1'b0; i_s_valid = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_job(vecs[0]);
    run_job(vecs[4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_pe_array_ctrl.md
# sw_pe_array_ctrl

Parametrised controller and systolic processing-element array for affine-gap Smith-Waterman local alignment. It loads a query S of up to PE_NUM bases into the array and streams a database T through it under a valid/ready handshake. It reports the best local score together with its end coordinates (S index, T index). It sits between the data processor, which supplies S and T bases, and the top-level control.

## Interface
- PE_NUM, 8: number of PE cells, which is also the maximum S length (≥2)
- SCORE_W, 10: width of scores and penalties (unsigned)
- T_LEN_W, 12: width of T length and T coordinates
- S_IDX_W, $clog2(PE_NUM)+1: width of S length and S coordinate

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- i_match  in  SCORE_W  bonus added on a base match
- i_mismatch  in  SCORE_W  penalty subtracted on a mismatch
- i_gap_open  in  SCORE_W  penalty for the first gap base
- i_gap_ext  in  SCORE_W  penalty for each further gap base
- i_start  in  1  job start pulse (IDLE only)
- i_clear  in  1  synchronous abort to IDLE
- i_s_len  in  S_IDX_W  S length, latched at start
- i_t_len  in  T_LEN_W  T length, latched at start
- i_s_base, i_s_valid / o_s_ready  in,in/out  2,1/1  S load handshake
- i_t_base, i_t_valid / o_t_ready  in,in/out  2,1/1  T stream handshake
- o_busy  out  1  high whenever the state is not IDLE
- o_done  out  1  one-cycle result pulse
- o_score  out  SCORE_W  best score
- o_s_end  out  S_IDX_W  S index of best cell (0-based)
- o_t_end  out  T_LEN_W  T index of best cell (0-based)

Base encoding: A=0, C=1, G=2, T=3. Penalty inputs are static for the duration of a job.

## Operation
- **States:** IDLE, LOAD, CALC, DRAIN, DONE.
- **IDLE:** On i_start, latch both lengths, clear the best-score register and go to LOAD. If i_s_len=0, i_s_len>PE_NUM or i_t_len=0, go directly to DONE with score 0 and ends 0.
- **LOAD:** o_s_ready=1. Each beat with i_s_valid high stores a base into PE[k] and increments k. After s_len beats, go to CALC. PEs with index ≥ s_len are disabled for the job.
- **CALC:** o_t_ready=1. The array advances only on accepted beats; a cycle without a beat stalls every PE and register. Each beat injects t_j into PE0 with a valid tag. After t_len beats, go to DRAIN.
- **DRAIN:** The array advances every cycle with invalid bubbles for s_len cycles, then goes to DONE.
- **DONE:** o_done=1 for one cycle, then IDLE. o_score, o_s_end and o_t_end hold until the next i_start.
- **Cell recurrence (PE k, T base j), all arithmetic saturating:**
  - Saturate at 0 on subtraction and at 2^SCORE_W−1 on addition.
  - sub = i_match if s_k==t_j, else −i_mismatch.
  - E(k,j) = max(H(k,j−1)−open, E(k,j−1)−ext). E is held inside the PE.
  - F(k,j) = max(H(k−1,j)−open, F(k−1,j)−ext). F comes from PE k−1.
  - H(k,j) = max(0, H(k−1,j−1)+sub, E, F).
  - Boundary values (row −1, column −1) are H=E=F=0.
- **Max tracking:**
  - Each advancing cycle, compare every PE output whose valid tag is set against the best register.
  - Update only on strictly greater H. Ties go to the earliest cycle, then to the lowest PE index.
  - If no score exceeds 0, the result is 0 with ends (0,0).
- **i_clear:** Any state returns to IDLE on the next edge. No o_done is produced. Results and PE state are cleared.
- **i_start outside IDLE:** Ignored.

## Timing
- **Reset values:** state IDLE. o_busy, o_done, o_s_ready, o_t_ready, o_score, o_s_end and o_t_end are all 0. All PE registers are 0.
- **Ready outputs:** o_s_ready and o_t_ready are registered and high for the whole of LOAD and CALC respectively. A beat is accepted on the edge where both valid and ready are high.
- **PE latency:** One advancing cycle per PE, so cell (k,j) is registered k advancing cycles after t_j is accepted.
- **Best-score register:** Updated on the advancing edge following the cell.
- **o_done latency:**
  - Normal job: o_done is high in the cycle following edge E+s_len+1, where E is the edge that accepts the last T beat. With no stalls, the total is s_len + t_len + s_len + 2 cycles after i_start.
  - Degenerate lengths: o_done arrives 2 cycles after i_start.
- **Reset mid-operation:** Immediate return to the reset values. Partially loaded data is discarded.

## Test plan
- **Exact match:** match=2, mismatch=1, open=3, ext=1; S=ACGT, T=ACGT → o_score=8, o_s_end=3, o_t_end=3. o_done arrives 4+1 edges after the last T beat.
- **No match:** S=AAAA, T=CCCC → o_score=0, ends (0,0), o_done asserted.
- **Gap:** S=ACGT, T=ACTGT → o_score=5, o_s_end=3, o_t_end=4.
- **Stall:** Repeat the gap case with random i_t_valid and i_s_valid gaps → identical results. o_done timing is unchanged relative to the last T beat.
- **Tie:** S=AC, T=ACAC → o_score=4, o_s_end=1, o_t_end=1 (the earlier cell wins).
- **Abort and reset:**
  - Assert i_clear mid-CALC → IDLE next cycle, no o_done.
  - Start a new job → correct result.
  - Pulse rst_n low mid-LOAD → all outputs 0 immediately.
  - i_s_len=0 → o_done 2 cycles after i_start with score 0.
